// File: rtl/benes_perm_loader.sv
// Serial permutation loader for the Benes routing path: collects N destination
// indices, flags malformed frames, builds the inverse and hands the frame off.
module benes_perm_loader #(
  parameter int LOG2N = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LOG2N-1:0]              in_idx,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [(2**LOG2N)*LOG2N-1:0]   out_perm,
  output logic [(2**LOG2N)*LOG2N-1:0]   out_inv,
  output logic                          out_err,
  output logic                          out_ident,
  output logic                          busy
);

  localparam int N = 2 ** LOG2N;
  localparam logic [LOG2N:0] LAST_CNT = (LOG2N + 1)'(N - 1);

  typedef enum logic [0:0] {
    ST_LOAD = 1'b0,
    ST_OUT  = 1'b1
  } state_e;

  state_e                         state_q, state_d;
  logic [LOG2N:0]                 cnt_q, cnt_d;
  logic [N-1:0][LOG2N-1:0]        perm_q, perm_d;
  logic [N-1:0][LOG2N-1:0]        inv_q, inv_d;
  logic [N-1:0]                   seen_q, seen_d;
  logic                           err_q, err_d;
  logic [LOG2N-1:0]               pos_s;
  logic                           accept_s;

  function automatic logic is_identity(input logic [N-1:0][LOG2N-1:0] p);
    logic r;
    r = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (p[i] != LOG2N'(i)) begin
        r = 1'b0;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  assign pos_s    = cnt_q[LOG2N-1:0];
  assign accept_s = in_valid && (state_q == ST_LOAD);

  // Next-state and frame-building logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    perm_d  = perm_q;
    inv_d   = inv_q;
    seen_d  = seen_q;
    err_d   = err_q;
    case (state_q)
      ST_LOAD: begin
        if (accept_s) begin
          perm_d[pos_s]  = in_idx;
          inv_d[in_idx]  = pos_s;
          seen_d[in_idx] = 1'b1;
          cnt_d          = cnt_q + (LOG2N + 1)'(1);
          if (seen_q[in_idx]) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          // A frame closes on in_last or on the N-th beat, whichever comes first.
          if (in_last) begin
            state_d = ST_OUT;
            if (cnt_q != LAST_CNT) begin
              err_d = 1'b1;
            end else begin
              err_d = err_d;
            end
          end else if (cnt_q == LAST_CNT) begin
            state_d = ST_OUT;
            err_d   = 1'b1;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_LOAD;
          cnt_d   = {(LOG2N + 1){1'b0}};
          perm_d  = {(N * LOG2N){1'b0}};
          inv_d   = {(N * LOG2N){1'b0}};
          seen_d  = {N{1'b0}};
          err_d   = 1'b0;
        end else begin
          state_d = ST_OUT;
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // State and frame storage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
      cnt_q   <= {(LOG2N + 1){1'b0}};
      perm_q  <= {(N * LOG2N){1'b0}};
      inv_q   <= {(N * LOG2N){1'b0}};
      seen_q  <= {N{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      perm_q  <= perm_d;
      inv_q   <= inv_d;
      seen_q  <= seen_d;
      err_q   <= err_d;
    end
  end

  // Status flags only mean something while a frame is being presented.
  assign in_ready  = (state_q == ST_LOAD);
  assign out_valid = (state_q == ST_OUT);
  assign out_perm  = perm_q;
  assign out_inv   = inv_q;
  assign out_err   = out_valid & err_q;
  assign out_ident = out_valid & ~err_q & is_identity(perm_q);
  assign busy      = (cnt_q != {(LOG2N + 1){1'b0}}) | out_valid;

endmodule

// File: tb/tb_benes_perm_loader.sv
// Directed + randomized bench for benes_perm_loader against a frame-level model.
module tb_benes_perm_loader;
  localparam int LOG2N = 3;
  localparam int N = 8;
  localparam int W = 3;

  logic clk, rst_n, in_valid, in_ready, in_last, out_valid, out_ready;
  logic out_err, out_ident, busy;
  logic [W-1:0] in_idx;
  logic [N*W-1:0] out_perm, out_inv;

  benes_perm_loader #(.LOG2N(LOG2N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_idx(in_idx), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_perm(out_perm), .out_inv(out_inv),
    .out_err(out_err), .out_ident(out_ident), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int b_idx[16];
  bit b_last[16];
  int blen;
  logic [N*W-1:0] exp_perm, exp_inv;
  logic exp_err, exp_ident;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Frame-level reference: perm is the beat list, inv takes the latest source
  // per destination, err means any repeat or a frame that is not N beats ending in last.
  task automatic build_model();
    int occ[N];
    exp_perm = '0;
    exp_inv  = '0;
    exp_err  = 1'b0;
    for (int d = 0; d < N; d++) occ[d] = 0;
    for (int k = 0; k < blen; k++) begin
      exp_perm[k*W +: W] = W'(b_idx[k]);
      exp_inv[b_idx[k]*W +: W] = W'(k);
      occ[b_idx[k]]++;
    end
    for (int d = 0; d < N; d++) if (occ[d] > 1) exp_err = 1'b1;
    if (blen != N || !b_last[N-1]) exp_err = 1'b1;
    exp_ident = !exp_err;
    for (int i = 0; i < N; i++) if (exp_perm[i*W +: W] != W'(i)) exp_ident = 1'b0;
  endtask

  task automatic set8(input int v[8], input bit with_last);
    blen = N;
    for (int k = 0; k < N; k++) begin
      b_idx[k]  = v[k];
      b_last[k] = with_last && (k == N - 1);
    end
  endtask

  task automatic rand_perm(input bit allow_dup);
    int t, j;
    blen = N;
    for (int k = 0; k < N; k++) begin
      b_idx[k]  = k;
      b_last[k] = (k == N - 1);
    end
    for (int k = N - 1; k > 0; k--) begin
      j = $urandom_range(k, 0);
      t = b_idx[k]; b_idx[k] = b_idx[j]; b_idx[j] = t;
    end
    if (allow_dup) b_idx[$urandom_range(N - 1, 0)] = $urandom_range(N - 1, 0);
  endtask

  task automatic send_frame(input string name, input int max_gap);
    int gap;
    build_model();
    for (int k = 0; k < blen; k++) begin
      gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
      repeat (gap) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
      @(negedge clk);
      check({name, "_in_ready"}, in_ready, 1'b1);
      check({name, "_early_valid"}, out_valid, 1'b0);
      in_valid = 1'b1;
      in_idx   = W'(b_idx[k]);
      in_last  = b_last[k];
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check({name, "_out_valid"}, out_valid, 1'b1);
    check({name, "_perm"}, out_perm, exp_perm);
    check({name, "_inv"}, out_inv, exp_inv);
    check({name, "_err"}, out_err, exp_err);
    check({name, "_ident"}, out_ident, exp_ident);
    check({name, "_busy"}, busy, 1'b1);
  endtask

  // Hold the frame under backpressure (with a stray beat offered), then accept it.
  task automatic release_frame(input string name, input int hold);
    for (int c = 0; c < hold; c++) begin
      in_valid = 1'b1;
      in_idx   = W'($urandom_range(N - 1, 0));
      in_last  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check({name, "_hold_valid"}, out_valid, 1'b1);
      check({name, "_hold_ready"}, in_ready, 1'b0);
      check({name, "_hold_perm"}, out_perm, exp_perm);
      check({name, "_hold_inv"}, out_inv, exp_inv);
      check({name, "_hold_err"}, out_err, exp_err);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_rel_valid"}, out_valid, 1'b0);
    check({name, "_rel_busy"}, busy, 1'b0);
    check({name, "_rel_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    int v[8];
    logic [N*W-1:0] inv_a;
    rst_n = 1'b0; in_valid = 1'b0; in_idx = '0; in_last = 1'b0; out_ready = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_err", out_err, 1'b0);
    check("rst_ident", out_ident, 1'b0);
    check("rst_perm", out_perm, '0);
    @(negedge clk);
    rst_n = 1'b1;

    v = '{6, 2, 5, 4, 0, 7, 1, 3};
    set8(v, 1'b1);
    send_frame("frame_a", 0);
    v = '{4, 6, 1, 7, 3, 2, 0, 5};
    for (int d = 0; d < N; d++) inv_a[d*W +: W] = W'(v[d]);
    check("frame_a_inv_const", out_inv, inv_a);
    release_frame("frame_a", 0);

    v = '{0, 1, 2, 3, 4, 5, 6, 7};
    set8(v, 1'b1);
    send_frame("ident", 0);
    release_frame("ident", 0);

    v = '{1, 1, 2, 3, 4, 5, 6, 7};
    set8(v, 1'b1);
    send_frame("dup", 0);
    check("dup_inv1", out_inv[1*W +: W], 3'd1);
    release_frame("dup", 0);

    rand_perm(1'b0);
    send_frame("after_dup", 0);
    release_frame("after_dup", 0);

    blen = 3;
    b_idx[0] = 1; b_idx[1] = 0; b_idx[2] = 2;
    b_last[0] = 1'b0; b_last[1] = 1'b0; b_last[2] = 1'b1;
    send_frame("early", 0);
    check("early_tail_zero", out_perm[N*W-1:3*W], '0);
    release_frame("early", 0);

    rand_perm(1'b0);
    for (int k = 0; k < N; k++) b_last[k] = 1'b0;
    send_frame("nolast", 0);
    release_frame("nolast", 5);

    rand_perm(1'b0);
    send_frame("post_bp", 0);
    release_frame("post_bp", 0);

    for (int r = 0; r < 8; r++) begin
      rand_perm(r[0]);
      send_frame("rand", 3);
      release_frame("rand", $urandom_range(3, 0));
    end

    rand_perm(1'b0);
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(2, 0)) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_idx   = W'(b_idx[k]);
      in_last  = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("abort_busy_pre", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort_busy_rst", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < N + 2; c++) begin
      @(negedge clk);
      check("abort_no_valid", out_valid, 1'b0);
    end

    rand_perm(1'b0);
    send_frame("post_abort", 2);
    release_frame("post_abort", 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
